// File: rtl/tone_scheduler.sv
// Tone scheduler: drives the tone divider period word and enable from live keys or a
// song ROM autoplay walk. Keys take priority over autoplay.
module tone_scheduler #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned NKEYS     = 8,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned GAP_UNITS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NKEYS-1:0]  key,
    input  logic              play_start,
    input  logic              play_stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [31:0]       div,
    output logic              tone_en,
    output logic              busy
);
    localparam int unsigned       TICK_DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned       PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [11:0]       GAP_LOAD   = (GAP_UNITS == 0) ? 12'd1 : 12'(GAP_UNITS);

    typedef enum logic [2:0] {IDLE, KEY, FETCH, LATCH, NOTE, GAP} state_t;

    function automatic logic [31:0] pitch_div(input logic [3:0] p);
        case (p)
            4'd1:    pitch_div = 32'(CLK_HZ / 262);
            4'd2:    pitch_div = 32'(CLK_HZ / 294);
            4'd3:    pitch_div = 32'(CLK_HZ / 330);
            4'd4:    pitch_div = 32'(CLK_HZ / 349);
            4'd5:    pitch_div = 32'(CLK_HZ / 392);
            4'd6:    pitch_div = 32'(CLK_HZ / 440);
            4'd7:    pitch_div = 32'(CLK_HZ / 494);
            4'd8:    pitch_div = 32'(CLK_HZ / 523);
            4'd9:    pitch_div = 32'(CLK_HZ / 587);
            4'd10:   pitch_div = 32'(CLK_HZ / 659);
            4'd11:   pitch_div = 32'(CLK_HZ / 698);
            4'd12:   pitch_div = 32'(CLK_HZ / 784);
            4'd13:   pitch_div = 32'(CLK_HZ / 880);
            4'd14:   pitch_div = 32'(CLK_HZ / 988);
            default: pitch_div = '0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       div_d;
    logic              en_d, busy_d;
    logic [11:0]       units_q, units_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [3:0]        key_pitch;
    logic [3:0]        rom_pitch;
    logic [11:0]       rom_dur;
    logic              period_end;

    assign rom_pitch  = rom_data[15:12];
    assign rom_dur    = rom_data[11:0];
    assign period_end = (presc_q == PRESC_LAST) && (units_q == 12'd1);

    // Scanning downward leaves the lowest pressed key's pitch in key_pitch.
    always_comb begin
        key_pitch = '0;
        for (int unsigned i = NKEYS; i > 0; i--) begin
            if (key[i-1]) key_pitch = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = rom_addr;
        div_d   = div;
        en_d    = tone_en;
        busy_d  = busy;
        units_d = units_q;
        presc_d = presc_q;

        if (state_q == NOTE || state_q == GAP) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                units_d = units_q - 12'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (key != '0) begin
            state_d = KEY;
            div_d   = pitch_div(key_pitch);
            en_d    = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play_start && !play_stop) begin
                        state_d = FETCH;
                        addr_d  = '0;
                        busy_d  = 1'b1;
                    end
                end
                KEY: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end
                default: begin
                    if (play_stop) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                    end else begin
                        case (state_q)
                            FETCH: state_d = LATCH;
                            LATCH: begin
                                if (rom_pitch == 4'hF) begin
                                    state_d = IDLE;
                                    busy_d  = 1'b0;
                                end else begin
                                    state_d = NOTE;
                                    units_d = (rom_dur == '0) ? 12'd1 : rom_dur;
                                    presc_d = '0;
                                    en_d    = (rom_pitch != 4'd0);
                                    if (rom_pitch != 4'd0) div_d = pitch_div(rom_pitch);
                                end
                            end
                            NOTE: begin
                                if (period_end) begin
                                    state_d = GAP;
                                    en_d    = 1'b0;
                                    units_d = GAP_LOAD;
                                    presc_d = '0;
                                end
                            end
                            GAP: begin
                                if (period_end) begin
                                    if (rom_addr == ADDR_LAST) begin
                                        state_d = IDLE;
                                        busy_d  = 1'b0;
                                    end else begin
                                        state_d = FETCH;
                                        addr_d  = rom_addr + ADDR_W'(1);
                                    end
                                end
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rom_addr <= '0;
            div      <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
            units_q  <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            rom_addr <= addr_d;
            div      <= div_d;
            tone_en  <= en_d;
            busy     <= busy_d;
            units_q  <= units_d;
            presc_q  <= presc_d;
        end
    end
endmodule

// File: tb/tb_tone_scheduler.sv
// Bench for tone_scheduler: a song-timeline model checked every cycle, directed literal
// checks, and a fast-tick instance that walks the whole 64-word ROM.
`timescale 1ns/1ps
module tb_tone_scheduler;
    localparam int unsigned CLK_HZ = 100_000_000;
    localparam int unsigned TDIV   = 100;
    localparam int unsigned GAPC   = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  key;
    logic        play_start, play_stop;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data;
    logic [31:0] div;
    logic        tone_en, busy;
    logic [15:0] rom [64];

    logic [7:0]  key2 = '0;
    logic        play_start2 = 1'b0, play_stop2 = 1'b0;
    logic [5:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic [31:0] div2;
    logic        tone_en2, busy2;

    tone_scheduler #(.CLK_HZ(CLK_HZ), .TICK_HZ(1_000_000), .NKEYS(8), .ADDR_W(6), .GAP_UNITS(20)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .play_start(play_start), .play_stop(play_stop),
        .rom_addr(rom_addr), .rom_data(rom_data), .div(div), .tone_en(tone_en), .busy(busy));

    // Fast instance: 10-cycle units, 2-unit gaps, so a full 64-note song stays short.
    tone_scheduler #(.CLK_HZ(CLK_HZ), .TICK_HZ(10_000_000), .NKEYS(8), .ADDR_W(6), .GAP_UNITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .key(key2), .play_start(play_start2), .play_stop(play_stop2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .div(div2), .tone_en(tone_en2), .busy(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data2 <= 16'h1000;

    int unsigned HZ [16] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 0};

    function automatic logic [31:0] div_of(input logic [3:0] p);
        return 32'(CLK_HZ / HZ[p]);
    endfunction

    function automatic logic [3:0] lowest_pitch(input logic [7:0] k);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 7; i >= 0; i--) if (k[i]) p = 4'(i + 1);
        return p;
    endfunction

    // Outputs e cycles after the start edge, found by walking the song's note blocks.
    function automatic void play_at(input int unsigned e, input logic [31:0] d0,
                                    output logic [31:0] d, output logic en,
                                    output logic bz, output logic [5:0] a);
        int unsigned rem, n;
        logic [3:0]  p;
        rem = e; d = d0; en = 1'b0; bz = 1'b1; a = '0;
        for (int k = 0; k < 64; k++) begin
            p = rom[k][15:12];
            n = (rom[k][11:0] == 12'd0) ? 1 : int'(rom[k][11:0]);
            n = n * TDIV;
            a = 6'(k);
            if (p == 4'hF) begin
                bz = (rem < 2);
                return;
            end
            if (rem < 2) return;
            if (p != 4'd0) d = div_of(p);
            if (rem < 2 + n) begin
                en = (p != 4'd0);
                return;
            end
            if (rem < 2 + n + GAPC) return;
            rem = rem - (2 + n + GAPC);
        end
        bz = 1'b0;
    endfunction

    typedef enum {M_IDLE, M_KEY, M_PLAY} mmode_t;
    mmode_t      mmode;
    int unsigned m_e;
    logic [31:0] m_div0, m_div;
    logic        m_en, m_busy;
    logic [5:0]  m_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmode = M_IDLE; m_div = '0; m_en = 1'b0; m_busy = 1'b0; m_addr = '0; m_e = 0; m_div0 = '0;
        end else if (key != 8'd0) begin
            mmode = M_KEY; m_div = div_of(lowest_pitch(key)); m_en = 1'b1; m_busy = 1'b0; m_addr = '0;
        end else if (mmode == M_KEY) begin
            mmode = M_IDLE; m_en = 1'b0;
        end else if (mmode == M_PLAY && play_stop) begin
            mmode = M_IDLE; m_en = 1'b0; m_busy = 1'b0; m_addr = '0;
        end else if (mmode == M_IDLE && play_start && !play_stop) begin
            mmode = M_PLAY; m_e = 0; m_div0 = m_div;
            play_at(m_e, m_div0, m_div, m_en, m_busy, m_addr);
        end else if (mmode == M_PLAY) begin
            m_e++;
            play_at(m_e, m_div0, m_div, m_en, m_busy, m_addr);
            if (!m_busy) mmode = M_IDLE;
        end
    end

    int checks = 0, passes = 0;

    always @(negedge clk) begin
        checks++;
        if (div === m_div && tone_en === m_en && busy === m_busy && rom_addr === m_addr) passes++;
        else $display("FAIL model t=%0t: div=%0d want %0d, tone_en=%b want %b, busy=%b want %b, rom_addr=%0d want %0d",
                      $time, div, m_div, tone_en, m_en, busy, m_busy, rom_addr, m_addr);
    end

    int tone_cnt, busy_cnt, tone2_cnt, busy2_cnt, jump2_cnt;
    logic [5:0] prev_addr2 = '0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (tone_en) tone_cnt++;
        if (busy2) begin
            busy2_cnt++;
            if (tone_en2) tone2_cnt++;
            if (rom_addr2 != prev_addr2 && int'(rom_addr2) != int'(prev_addr2) + 1) jump2_cnt++;
        end
        prev_addr2 = rom_addr2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; key = '0; play_start = 1'b0; play_stop = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 16'hF000;
        step(3);
        chk("reset div", div, 0);
        chk("reset tone_en", 32'(tone_en), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset rom_addr", 32'(rom_addr), 0);
        rst_n = 1'b1;
        step(2);

        key = 8'b0010_0100; step(1);
        chk("key E4 div", div, 303030);
        chk("key E4 tone_en", 32'(tone_en), 1);
        key = 8'b0000_0000; step(1);
        chk("key release tone_en", 32'(tone_en), 0);
        chk("key release div holds", div, 303030);
        key = 8'b1000_0000; step(1);
        chk("key C5 div", div, 191204);
        key = 8'b1100_0000; step(1);
        chk("key change B4 div", div, 202429);
        key = 8'b0000_0000; step(2);

        rom[0] = 16'h6003; rom[1] = 16'h0002; rom[2] = 16'hF000;
        play_start = 1'b1; step(1); play_start = 1'b0;
        chk("play busy", 32'(busy), 1);
        chk("play rom_addr", 32'(rom_addr), 0);
        tone_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 6000 && busy; i++) step(1);
        chk("song finished", 32'(busy), 0);
        chk("song tone cycles", 32'(tone_cnt), 300);
        chk("song busy cycles", 32'(busy_cnt), 4506);
        chk("song final div", div, 227272);
        chk("song final rom_addr", 32'(rom_addr), 2);
        step(3);

        play_start = 1'b1; step(1); play_start = 1'b0;
        step(99);
        chk("abort pre tone_en", 32'(tone_en), 1);
        chk("abort pre div", div, 227272);
        key = 8'b0000_0001; step(1);
        chk("abort div", div, 381679);
        chk("abort busy", 32'(busy), 0);
        chk("abort tone_en", 32'(tone_en), 1);
        key = 8'b0000_0000; step(1);
        chk("abort release tone_en", 32'(tone_en), 0);
        step(3);

        play_start = 1'b1; step(1); play_start = 1'b0;
        step(399);
        chk("gap busy", 32'(busy), 1);
        chk("gap tone_en", 32'(tone_en), 0);
        play_start = 1'b1; step(1); play_start = 1'b0;
        step(2200);
        chk("second gap rom_addr", 32'(rom_addr), 1);
        chk("second gap busy", 32'(busy), 1);
        play_stop = 1'b1; step(1); play_stop = 1'b0;
        chk("stop busy", 32'(busy), 0);
        chk("stop tone_en", 32'(tone_en), 0);
        chk("stop rom_addr", 32'(rom_addr), 0);
        step(3);

        play_start = 1'b1; step(1); play_start = 1'b0;
        step(49);
        chk("pre-reset tone_en", 32'(tone_en), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset div", div, 0);
        chk("async reset tone_en", 32'(tone_en), 0);
        chk("async reset busy", 32'(busy), 0);
        chk("async reset rom_addr", 32'(rom_addr), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(5);
        chk("after reset busy", 32'(busy), 0);
        chk("after reset tone_en", 32'(tone_en), 0);
        chk("after reset div", div, 0);

        play_start2 = 1'b1; step(1); play_start2 = 1'b0;
        tone2_cnt = 0; busy2_cnt = 0; jump2_cnt = 0;
        for (int i = 0; i < 3000 && busy2; i++) step(1);
        chk("full rom finished", 32'(busy2), 0);
        chk("full rom busy cycles", 32'(busy2_cnt), 2048);
        chk("full rom tone cycles", 32'(tone2_cnt), 640);
        chk("full rom addr jumps", 32'(jump2_cnt), 0);
        chk("full rom last addr", 32'(rom_addr2), 63);
        chk("full rom div", div2, 381679);
        step(40);
        chk("full rom stays idle", 32'(busy2), 0);
        chk("full rom no wrap", 32'(rom_addr2), 63);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
